// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: stall bus type and encodings, divide FSM states.
package pipe_ctrl_pkg;

    localparam int STALL_WD = 6;

    typedef logic [STALL_WD-1:0] stall_bus_t;

    // Bit k holds pipeline register k; bit0 is the PC, bit5 is WB.
    localparam stall_bus_t STALL_NONE = 6'b000000;
    localparam stall_bus_t STALL_ID   = 6'b000111;
    localparam stall_bus_t STALL_EX   = 6'b001111;
    localparam stall_bus_t STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    function automatic stall_bus_t stall_encode(input logic mem, input logic ex, input logic id);
        if (mem) begin
            return STALL_MEM;
        end
        if (ex) begin
            return STALL_EX;
        end
        if (id) begin
            return STALL_ID;
        end
        return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_div_seq.sv
// Divide sequencer: start/ready handshake with the iterative divider and the EX stall request.
// Optional BUSY watchdog under CTRL_DIV_WATCHDOG_EN; otherwise BUSY waits for div_ready indefinitely.
module pipe_ctrl_div_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ex_div_req,
    input  logic i_div_ready,
    input  logic i_mem_hold,
    output logic o_div_start,
    output logic o_div_busy,
    output logic o_ex_stall_req,
    output logic o_div_timeout
);

    div_state_e r_state;
    div_state_e w_next;
    logic       w_wd_fire;

`ifdef CTRL_DIV_WATCHDOG_EN
    localparam int WD_W = $clog2(DIV_TIMEOUT + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_timeout;

    assign w_wd_fire = (r_state == ST_BUSY) && !i_div_ready &&
                       (r_wd_cnt == WD_W'(DIV_TIMEOUT - 1));

    // Held at zero outside BUSY, so every BUSY entry starts a fresh count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state != ST_BUSY) begin
                r_wd_cnt <= '0;
            end else if (!w_wd_fire) begin
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
            end
            if (w_wd_fire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_div_timeout = r_timeout;
`else
    localparam int unused_div_timeout = DIV_TIMEOUT;

    assign w_wd_fire     = 1'b0;
    assign o_div_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        o_div_start    = 1'b0;
        o_div_busy     = 1'b0;
        o_ex_stall_req = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_ex_div_req) begin
                    o_div_start    = 1'b1;
                    o_ex_stall_req = 1'b1;
                    w_next         = ST_BUSY;
                end
            end
            ST_BUSY: begin
                o_div_busy     = 1'b1;
                o_ex_stall_req = 1'b1;
                if (i_div_ready || w_wd_fire) begin
                    w_next = ST_DONE;
                end
            end
            // The one-cycle release is only meaningful once MEM stops holding the pipe.
            ST_DONE: begin
                if (!i_mem_hold) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (!rst) begin
            o_div_start    = 1'b0;
            o_div_busy     = 1'b0;
            o_ex_stall_req = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall controller: prioritises MEM/EX/ID stall requests onto the stall bus and counts stalled cycles.
// Divider watchdog is enabled by defining CTRL_DIV_WATCHDOG_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_WD      = 32,
    parameter int DIV_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                stallreq_mem,
    input  logic                ex_div_req,
    input  logic                div_ready,
    output logic                div_start,
    output logic [STALL_WD-1:0] stall,
    output logic                div_busy,
    output logic [CNT_WD-1:0]   stall_cycles,
    output logic                div_timeout
);

    logic        w_ex_stall_req;
    stall_bus_t  w_stall;
    logic [CNT_WD-1:0] r_stall_cycles;

    pipe_ctrl_div_seq #(
        .DIV_TIMEOUT(DIV_TIMEOUT)
    ) u_div_seq (
        .clk           (clk),
        .rst           (rst),
        .i_ex_div_req  (ex_div_req),
        .i_div_ready   (div_ready),
        .i_mem_hold    (stallreq_mem),
        .o_div_start   (div_start),
        .o_div_busy    (div_busy),
        .o_ex_stall_req(w_ex_stall_req),
        .o_div_timeout (div_timeout)
    );

    // Lower-priority requests are masked, not queued; the requester keeps asserting.
    always_comb begin
        w_stall = STALL_NONE;
        if (rst) begin
            w_stall = stall_encode(stallreq_mem, w_ex_stall_req, stallreq_id);
        end
    end

    assign stall = w_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
        end else if ((w_stall != STALL_NONE) && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + CNT_WD'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table plus sequences for divide, reset, watchdog and saturation.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stallreq_id, stallreq_mem, ex_div_req, div_ready;
    logic        div_start, div_busy, div_timeout;
    logic [5:0]  stall;
    logic [31:0] stall_cycles;

    logic        s_id;
    logic        s_start, s_busy, s_timeout;
    logic [5:0]  s_stall;
    logic [2:0]  s_cnt;

    pipe_ctrl u_dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_id (stallreq_id),
        .stallreq_mem(stallreq_mem),
        .ex_div_req  (ex_div_req),
        .div_ready   (div_ready),
        .div_start   (div_start),
        .stall       (stall),
        .div_busy    (div_busy),
        .stall_cycles(stall_cycles),
        .div_timeout (div_timeout)
    );

    // Narrow counter instance so saturation is reached in a few cycles.
    pipe_ctrl #(.CNT_WD(3)) u_sat (
        .clk         (clk),
        .rst         (rst),
        .stallreq_id (s_id),
        .stallreq_mem(1'b0),
        .ex_div_req  (1'b0),
        .div_ready   (1'b0),
        .div_start   (s_start),
        .stall       (s_stall),
        .div_busy    (s_busy),
        .stall_cycles(s_cnt),
        .div_timeout (s_timeout)
    );

    typedef struct {
        logic        id;
        logic        mem;
        logic        req;
        logic        rdy;
        logic [5:0]  exp_stall;
        logic        exp_start;
        logic        exp_busy;
        logic [31:0] exp_cnt;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic id, input logic mem, input logic req, input logic rdy);
        stallreq_id  = id;
        stallreq_mem = mem;
        ex_div_req   = req;
        div_ready    = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        s_id = 1'b0;
        next_cycle();
        rst = 1'b1;
    endtask

    initial begin
        int starts;
        int errs;

        //               id    mem   req   rdy   stall      start busy  cnt
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 32'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000111, 1'b0, 1'b0, 32'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 32'd1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b011111, 1'b0, 1'b0, 32'd1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b011111, 1'b0, 1'b0, 32'd2};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b001111, 1'b1, 1'b0, 32'd3};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'b001111, 1'b0, 1'b1, 32'd4};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 6'b011111, 1'b0, 1'b1, 32'd5};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 6'b011111, 1'b0, 1'b1, 32'd6};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b011111, 1'b0, 1'b0, 32'd7};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b0, 32'd8};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 32'd8};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 32'd8};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000111, 1'b0, 1'b0, 32'd8};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 32'd9};

        // Reset holds outputs low even with every request asserted.
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        s_id = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_start", 32'(div_start), 32'd0);
        chk("rst_busy", 32'(div_busy), 32'd0);
        chk("rst_cnt", stall_cycles, 32'd0);
        chk("rst_timeout", 32'(div_timeout), 32'd0);
        chk("rst_sat_cnt", 32'(s_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        s_id = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].id, vecs[i].mem, vecs[i].req, vecs[i].rdy);
            settle();
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            chk($sformatf("v%0d_start", i), 32'(div_start), 32'(vecs[i].exp_start));
            chk($sformatf("v%0d_busy", i), 32'(div_busy), 32'(vecs[i].exp_busy));
            chk($sformatf("v%0d_cnt", i), stall_cycles, vecs[i].exp_cnt);
            next_cycle();
        end

        // Divide with ready at T0+33: stall T0..T0+33, release at T0+34.
        reset_pulse();
        starts = 0;
        errs   = 0;
        for (int k = 0; k <= 34; k++) begin
            drive(1'b0, 1'b0, 1'b1, (k == 33));
            settle();
            if (div_start) starts++;
            if (k <= 33 && stall != STALL_EX) errs++;
            if (k == 1) chk("div_busy_t1", 32'(div_busy), 32'd1);
            if (k == 34) begin
                chk("div_release_stall", 32'(stall), 32'd0);
                chk("div_release_busy", 32'(div_busy), 32'd0);
            end
            next_cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("div_stall_hold_errs", 32'(errs), 32'd0);
        chk("div_start_count", 32'(starts), 32'd1);
        chk("div_no_restart", 32'(div_start), 32'd0);
        chk("div_cnt", stall_cycles, 32'd34);
        next_cycle();

        // Reset asserted mid-BUSY in the third cycle of a divide.
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        next_cycle();
        next_cycle();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_busy", 32'(div_busy), 32'd0);
        chk("midrst_start", 32'(div_start), 32'd0);
        chk("midrst_cnt", stall_cycles, 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        errs = 0;
        for (int k = 0; k < 3; k++) begin
            settle();
            if (div_start || div_busy || stall != STALL_NONE) errs++;
            next_cycle();
        end
        chk("postrst_idle_errs", 32'(errs), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        chk("postrst_start", 32'(div_start), 32'd1);
        chk("postrst_stall", 32'(stall), 32'(STALL_EX));
        next_cycle();

        // Divider that never answers.
        reset_pulse();
        errs = 0;
`ifdef CTRL_DIV_WATCHDOG_EN
        for (int k = 0; k <= 64; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            settle();
            if (stall != STALL_EX || div_timeout) errs++;
            if (k > 0 && !div_busy) errs++;
            next_cycle();
        end
        chk("wd_busy_errs", 32'(errs), 32'd0);
        settle();
        chk("wd_release_stall", 32'(stall), 32'd0);
        chk("wd_timeout_set", 32'(div_timeout), 32'd1);
        chk("wd_release_busy", 32'(div_busy), 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("wd_idle_stall", 32'(stall), 32'd0);
        chk("wd_idle_start", 32'(div_start), 32'd0);
        chk("wd_timeout_sticky", 32'(div_timeout), 32'd1);
        next_cycle();
`else
        for (int k = 0; k <= 100; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            settle();
            if (stall != STALL_EX) errs++;
            if (k > 0 && !div_busy) errs++;
            next_cycle();
        end
        chk("nowd_hold_errs", 32'(errs), 32'd0);
        chk("nowd_timeout", 32'(div_timeout), 32'd0);
        chk("nowd_cnt", stall_cycles, 32'd101);
`endif

        // Saturation on the 3-bit counter: 6, then three more stalls end at 7.
        reset_pulse();
        s_id = 1'b1;
        for (int k = 0; k < 9; k++) begin
            settle();
            if (k == 0) chk("sat_stall", 32'(s_stall), 32'(STALL_ID));
            if (k == 6) chk("sat_cnt_pre", 32'(s_cnt), 32'd6);
            next_cycle();
        end
        s_id = 1'b0;
        settle();
        chk("sat_cnt_final", 32'(s_cnt), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall controller for the 5-stage core; replaces the current reset-only control unit.
- Merges stall requests from ID (load-use), EX (multi-cycle divide) and MEM (data-port wait) into the 6-bit stall bus.
- Sequences the external iterative divider with a start/ready handshake.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- STALL_WD, 6, stall bus width (bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB).
- CNT_WD, 32, stall-cycle counter width.
- DIV_TIMEOUT, 64, BUSY cycles before watchdog fires (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stallreq_id  in  1  load-use hazard from ID, combinational.
- stallreq_mem  in  1  MEM stage waiting on the data port.
- ex_div_req  in  1  EX holds a div/divu instruction.
- div_ready  in  1  divider result valid; one-cycle pulse.
- div_start  out  1  one-cycle pulse that starts the divider.
- stall  out  STALL_WD  hold mask to pipeline registers; held-stage k with k+1 not held inserts a bubble.
- div_busy  out  1  high while state is BUSY.
- stall_cycles  out  CNT_WD  count of cycles with stall != 0, saturating.
- div_timeout  out  1  sticky watchdog flag; tied 0 without the optional feature.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, stall_cycles=0, div_timeout=0.
  - stall, div_start and div_busy are forced to 0 regardless of inputs for as long as rst=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE and ex_div_req=1: div_start=1 (combinational, same cycle); EX stall request active; next state BUSY.
  - BUSY: div_start=0; EX stall request active; div_busy=1.
  - BUSY and div_ready=1: next state DONE. The stall stays active in this cycle; the result is latched by EX.
  - DONE: EX stall request inactive for exactly one cycle so the divide advances. ex_div_req may still be 1 here and must not retrigger div_start. Next state IDLE.
  - A div_ready seen in IDLE or DONE is ignored.
- Stall encoding, combinational, highest priority first:
  - stallreq_mem: 011111.
  - EX stall request (IDLE with ex_div_req=1, or BUSY): 001111.
  - stallreq_id: 000111.
  - otherwise 000000.
  - Simultaneous requests take the highest priority; lower requests are masked, not queued.
- While stallreq_mem holds the stall in BUSY, the FSM still advances on div_ready. DONE is held, and its one-cycle release deferred, until stallreq_mem=0.
- stall_cycles: increments by 1 each cycle stall != 0; saturates at all-ones and does not wrap.
- No internal flush; branch handling stays in ID.

Optional Feature:
- Macro: CTRL_DIV_WATCHDOG_EN.
- Defined:
  - A BUSY-cycle counter is cleared on entry to BUSY.
  - When it reaches DIV_TIMEOUT with no div_ready, div_timeout is set (sticky until reset) and the FSM forces BUSY -> DONE. The instruction is released with whatever result EX holds.
- Undefined: no counter, div_timeout=0, BUSY waits indefinitely.

Decomposition:
- Shared defines header holds:
  - StallBus width.
  - Stall encodings STALL_NONE=000000, STALL_ID=000111, STALL_EX=001111, STALL_MEM=011111.
  - FSM state encodings (2-bit).
- One sub-module, pipe_ctrl_div_seq: the divide FSM plus watchdog; outputs div_start, div_busy, ex_stall_req. The top level does priority encoding and the counter.

Test Plan:
- Reset mid-BUSY: start a divide, drop rst in cycle 3 -> stall=000000, div_busy=0, stall_cycles=0 immediately; after release, IDLE with no div_start until ex_div_req rises again.
- Load-use: stallreq_id=1 for 1 cycle -> stall=000111 that cycle, stall_cycles=1.
- Divide: ex_div_req=1 at T0, div_ready at T0+33 ->
  - div_start only at T0;
  - stall=001111 T0..T0+33, 000000 at T0+34;
  - stall_cycles=34;
  - no second div_start.
- Priority: stallreq_mem=1 and stallreq_id=1 with a divide in BUSY -> stall=011111; div_ready during this -> DONE held; release cycle occurs only after stallreq_mem drops.
- Saturation: preload counter (force) to all-ones minus 1, stall for 3 cycles -> counter stays all-ones.
- With CTRL_DIV_WATCHDOG_EN, DIV_TIMEOUT=64, divider never ready -> div_timeout=1 after 64 BUSY cycles, one release cycle, then IDLE. Without the macro -> stall holds 001111 indefinitely.
